// File: rtl/sr_ctrl.sv
// Status register (R2) controller: flag merge, explicit writes, and the
// interrupt-entry push/clear and RETI pop sequencing against the stack unit.
module sr_ctrl #(
    parameter logic [15:0] RESET_SR      = 16'h0000,
    parameter logic [15:0] IRQ_KEEP_MASK = 16'h0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flag_upd,
    input  logic [3:0]  flag_mask,
    input  logic [3:0]  cvnz_in,
    input  logic        sr_wr_en,
    input  logic [15:0] sr_wr_data,
    input  logic        irq_req,
    input  logic        reti,
    input  logic        push_ready,
    input  logic        pop_valid,
    input  logic [15:0] pop_data,
    output logic [15:0] sr_q,
    output logic        MSR,
    output logic        push_valid,
    output logic [15:0] push_data,
    output logic        pop_req,
    output logic        irq_ack,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PUSH = 2'd1;
    localparam logic [1:0] S_CLR  = 2'd2;
    localparam logic [1:0] S_POP  = 2'd3;

    localparam logic [15:0] SR_IMPL_MASK = 16'h01FF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_sr;
    logic        w_idle;

    // flag_mask / cvnz_in order is {V,N,Z,C}; V lives at SR bit 8, the rest at 2:0.
    function automatic logic [15:0] merge_flags(input logic [15:0] sr,
                                                input logic [3:0]  mask,
                                                input logic [3:0]  cvnz);
        logic [15:0] res;
        res = sr;
        if (mask[0]) res[0] = cvnz[0];
        if (mask[1]) res[1] = cvnz[1];
        if (mask[2]) res[2] = cvnz[2];
        if (mask[3]) res[8] = cvnz[3];
        return res & SR_IMPL_MASK;
    endfunction

    assign w_idle = (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (reti)                  w_state_nxt = S_POP;
                else if (irq_req && r_sr[3]) w_state_nxt = S_PUSH;
            end
            S_PUSH:  if (push_ready) w_state_nxt = S_CLR;
            S_CLR:   w_state_nxt = S_IDLE;
            S_POP:   if (pop_valid)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Writes in IDLE land even on the edge that leaves IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= RESET_SR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sr_wr_en)      r_sr <= sr_wr_data & SR_IMPL_MASK;
                    else if (flag_upd) r_sr <= merge_flags(r_sr, flag_mask, cvnz_in);
                end
                S_CLR:   r_sr <= r_sr & IRQ_KEEP_MASK & SR_IMPL_MASK;
                S_POP:   if (pop_valid) r_sr <= pop_data & SR_IMPL_MASK;
                default: r_sr <= r_sr;
            endcase
        end
    end

    assign sr_q       = r_sr;
    assign MSR        = flag_upd & ~sr_wr_en & w_idle;
    assign push_valid = (r_state == S_PUSH);
    assign push_data  = r_sr;
    assign pop_req    = (r_state == S_POP);
    assign irq_ack    = (r_state == S_CLR);
    assign busy       = ~w_idle;

endmodule

// File: tb/tb_sr_ctrl.sv
// Self-checking bench for sr_ctrl: table-driven IDLE write/merge vectors with a
// scoreboard queue, plus hand-written interrupt, RETI and reset sequences.
module tb_sr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag_upd;
    logic [3:0]  flag_mask;
    logic [3:0]  cvnz_in;
    logic        sr_wr_en;
    logic [15:0] sr_wr_data;
    logic        irq_req;
    logic        reti;
    logic        push_ready;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic [15:0] sr_q;
    logic        MSR;
    logic        push_valid;
    logic [15:0] push_data;
    logic        pop_req;
    logic        irq_ack;
    logic        busy;

    always #5 clk = ~clk;

    sr_ctrl #(
        .RESET_SR     (16'h0000),
        .IRQ_KEEP_MASK(16'h0040)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_upd  (flag_upd),
        .flag_mask (flag_mask),
        .cvnz_in   (cvnz_in),
        .sr_wr_en  (sr_wr_en),
        .sr_wr_data(sr_wr_data),
        .irq_req   (irq_req),
        .reti      (reti),
        .push_ready(push_ready),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .sr_q      (sr_q),
        .MSR       (MSR),
        .push_valid(push_valid),
        .push_data (push_data),
        .pop_req   (pop_req),
        .irq_ack   (irq_ack),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] init;
        logic        wr_en;
        logic [15:0] wr_data;
        logic        fu;
        logic [3:0]  mask;
        logic [3:0]  cvnz;
        logic [15:0] exp_sr;
        logic        exp_msr;
    } vec_t;

    vec_t        tbl[8];
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        sr_wr_en   = 1'b1;
        sr_wr_data = v;
        step();
        sr_wr_en   = 1'b0;
        chk("load_sr", sr_q, v & 16'h01FF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0008, 1'b0, 16'h0000, 1'b1, 4'b1011, 4'b1111, 16'h010B, 1'b1};
        tbl[1] = '{16'h0000, 1'b1, 16'hFFFF, 1'b1, 4'b1111, 4'b0000, 16'h01FF, 1'b0};
        tbl[2] = '{16'h01FF, 1'b0, 16'h0000, 1'b1, 4'b1111, 4'b0000, 16'h00F8, 1'b1};
        tbl[3] = '{16'h00F0, 1'b0, 16'h0000, 1'b1, 4'b0000, 4'b1111, 16'h00F0, 1'b1};
        tbl[4] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'b1111, 16'h0000, 1'b0};
        tbl[5] = '{16'h0055, 1'b1, 16'h1234, 1'b0, 4'b0000, 4'b0000, 16'h0034, 1'b0};
        tbl[6] = '{16'h0104, 1'b0, 16'h0000, 1'b1, 4'b0100, 4'b0000, 16'h0100, 1'b1};
        tbl[7] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 4'b1000, 4'b1000, 16'h0100, 1'b1};

        rst = 1'b1; flag_upd = 1'b0; flag_mask = 4'h0; cvnz_in = 4'h0;
        sr_wr_en = 1'b0; sr_wr_data = 16'h0; irq_req = 1'b0; reti = 1'b0;
        push_ready = 1'b0; pop_valid = 1'b0; pop_data = 16'h0;

        // Reset state
        #2;
        chk("rst_sr", sr_q, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_push_valid", push_valid, 0);
        chk("rst_pop_req", pop_req, 0);
        chk("rst_irq_ack", irq_ack, 0);
        chk("rst_msr", MSR, 0);
        step();
        step();
        rst = 1'b0;

        // Table: IDLE explicit writes and flag merges
        for (int i = 0; i < 8; i++) begin
            load(tbl[i].init);
            sr_wr_en   = tbl[i].wr_en;
            sr_wr_data = tbl[i].wr_data;
            flag_upd   = tbl[i].fu;
            flag_mask  = tbl[i].mask;
            cvnz_in    = tbl[i].cvnz;
            #1;
            chk($sformatf("tbl%0d_msr", i), MSR, tbl[i].exp_msr);
            exp_q.push_back(tbl[i].exp_sr);
            step();
            sr_wr_en = 1'b0;
            flag_upd = 1'b0;
            chk($sformatf("tbl%0d_sr", i), sr_q, exp_q.pop_front());
        end

        // Interrupt entry with push_ready stalled two cycles; writes ignored while busy
        load(16'h00DF);
        irq_req    = 1'b1;
        push_ready = 1'b0;
        #1 chk("irq_idle_busy", busy, 0);
        step();
        for (int c = 0; c < 3; c++) begin
            push_ready = (c == 2);
            sr_wr_en   = 1'b1;
            sr_wr_data = 16'h0000;
            flag_upd   = 1'b1;
            flag_mask  = 4'hF;
            #1;
            chk($sformatf("push%0d_valid", c), push_valid, 1);
            chk($sformatf("push%0d_data", c), push_data, 16'h00DF);
            chk($sformatf("push%0d_busy", c), busy, 1);
            chk($sformatf("push%0d_msr", c), MSR, 0);
            chk($sformatf("push%0d_ack", c), irq_ack, 0);
            step();
        end
        sr_wr_en = 1'b0; flag_upd = 1'b0; irq_req = 1'b0; push_ready = 1'b0;
        chk("clr_ack", irq_ack, 1);
        chk("clr_push_valid", push_valid, 0);
        chk("clr_sr_hold", sr_q, 16'h00DF);
        step();
        chk("irq_done_sr", sr_q, 16'h0040);
        chk("irq_done_ack", irq_ack, 0);
        chk("irq_done_busy", busy, 0);

        // Minimum entry latency with push_ready tied high
        load(16'h0008);
        irq_req    = 1'b1;
        push_ready = 1'b1;
        lat = 0;
        do begin
            step();
            irq_req = 1'b0;
            lat++;
        end while (busy && lat < 10);
        chk("irq_latency", lat, 3);
        chk("irq_latency_sr", sr_q, 16'h0000);
        push_ready = 1'b0;

        // IDLE write on the same edge as the IDLE->PUSH transition
        load(16'h0008);
        sr_wr_en   = 1'b1;
        sr_wr_data = 16'h00C8;
        irq_req    = 1'b1;
        push_ready = 1'b1;
        step();
        sr_wr_en = 1'b0; irq_req = 1'b0;
        chk("wrtr_sr", sr_q, 16'h00C8);
        chk("wrtr_push_valid", push_valid, 1);
        chk("wrtr_push_data", push_data, 16'h00C8);
        step();
        chk("wrtr_ack", irq_ack, 1);
        step();
        push_ready = 1'b0;
        chk("wrtr_sr_end", sr_q, 16'h0040);

        // GIE clear: irq_req held for 10 cycles has no effect
        load(16'h0000);
        irq_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("gie%0d_busy", c), busy, 0);
            chk($sformatf("gie%0d_push", c), push_valid, 0);
            chk($sformatf("gie%0d_ack", c), irq_ack, 0);
        end
        irq_req = 1'b0;

        // RETI and irq_req on the same cycle: RETI wins
        load(16'h0008);
        reti = 1'b1; irq_req = 1'b1; pop_valid = 1'b0;
        step();
        reti = 1'b0;
        chk("reti_pop_req", pop_req, 1);
        chk("reti_push_valid", push_valid, 0);
        chk("reti_busy", busy, 1);
        pop_valid = 1'b1; pop_data = 16'hFE18; irq_req = 1'b0;
        step();
        pop_valid = 1'b0;
        chk("reti_sr", sr_q, 16'h0018);
        chk("reti_busy_end", busy, 0);
        chk("reti_pop_req_end", pop_req, 0);
        chk("reti_push_end", push_valid, 0);

        // Reset mid-PUSH abandons the entry
        load(16'h0008);
        irq_req = 1'b1; push_ready = 1'b0;
        step();
        chk("rpush_valid_pre", push_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rpush_valid", push_valid, 0);
        chk("rpush_sr", sr_q, 16'h0000);
        chk("rpush_busy", busy, 0);
        irq_req = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rpush%0d_ack", c), irq_ack, 0);
            chk($sformatf("rpush%0d_busy", c), busy, 0);
        end

        // Reset mid-POP; later pop_valid is ignored in IDLE
        load(16'h0055);
        reti = 1'b1;
        step();
        reti = 1'b0;
        chk("rpop_req_pre", pop_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rpop_req", pop_req, 0);
        chk("rpop_sr", sr_q, 16'h0000);
        step();
        rst = 1'b0;
        pop_valid = 1'b1; pop_data = 16'hFFFF;
        step();
        pop_valid = 1'b0;
        chk("rpop_sr_after", sr_q, 16'h0000);
        chk("rpop_busy_after", busy, 0);
        load(16'h0123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
